shift_issue_stage: RTL and testbench

//  Execute-issue stage directly upstream of the barrel shifter. Decodes RV32I shift instructions
//  (SLL/SRL/SRA, SLLI/SRLI/SRAI) and selects the shift source and amount. Drives the shifter

---
 rtl/shift_pkg.sv | 28 ++
 rtl/shift_decode.sv | 46 ++++
 rtl/shift_issue_stage.sv | 126 ++++++++++++
 tb/tb_shift_issue_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared constants and the decoded shift-op record for the shift issue stage.
package shift_pkg;

  localparam int unsigned SHIFT_XLEN = 32;
  localparam int unsigned SHAMT_W    = $clog2(SHIFT_XLEN);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_SRA     = 7'b0100000;

  localparam logic DIR_LEFT   = 1'b1;
  localparam logic DIR_RIGHT  = 1'b0;
  localparam logic SIGN_ARITH = 1'b1;
  localparam logic SIGN_LOGIC = 1'b0;

  typedef struct packed {
    logic [SHIFT_XLEN-1:0] src;
    logic [SHAMT_W-1:0]    num;
    logic                  dir;
    logic                  sign;
    logic [4:0]            rd;
    logic                  illegal;
  } shift_op_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational RV32I shift decoder: instruction word plus operands -> shifter controls.
module shift_decode
  import shift_pkg::*;
(
  input  logic [31:0]           instr,
  input  logic [SHIFT_XLEN-1:0] rs1_val,
  input  logic [SHIFT_XLEN-1:0] rs2_val,
  output shift_op_t             op
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_reg;
  logic       is_imm;
  logic       legal;
  logic       unused_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign is_reg = (opcode == OPC_OP);
  assign is_imm = (opcode == OPC_OP_IMM);

  // Imm forms with instr[25]=1 fail the funct7 match, so they fall out as illegal here.
  assign legal = (is_reg || is_imm) &&
                 (((funct3 == F3_SLL) && (funct7 == F7_BASE)) ||
                  ((funct3 == F3_SR) && ((funct7 == F7_BASE) || (funct7 == F7_SRA))));

  assign unused_bits = ^{instr[19:15], rs2_val[SHIFT_XLEN-1:SHAMT_W]};

  always_comb begin
    op         = '0;
    op.src     = rs1_val;
    op.rd      = instr[11:7];
    op.illegal = !legal;
    op.dir     = DIR_RIGHT;
    op.sign    = SIGN_LOGIC;
    if (legal) begin
      op.num  = is_reg ? rs2_val[SHAMT_W-1:0] : instr[20 +: SHAMT_W];
      op.dir  = (funct3 == F3_SLL) ? DIR_LEFT : DIR_RIGHT;
      op.sign = ((funct3 == F3_SR) && instr[30]) ? SIGN_ARITH : SIGN_LOGIC;
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Shift issue stage: decode feeding a registered 2-entry skid buffer in front of the shifter.
// Optional write-back operand forwarding at capture is enabled by SHIFT_ISSUE_FWD_EN.
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
`ifdef SHIFT_ISSUE_FWD_EN
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_src,
  output logic [XLEN-1:0] out_num,
  output logic            out_dir,
  output logic            out_sign,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  if (XLEN != 32) begin : gen_xlen_check
    $error("shift_issue_stage: only XLEN=32 is supported");
  end

  logic [XLEN-1:0] rs1_cap;
  logic [XLEN-1:0] rs2_cap;
  shift_op_t       dec_op;

`ifdef SHIFT_ISSUE_FWD_EN
  logic fwd_rs1;
  logic fwd_rs2;
  // rs2 only feeds the amount of reg forms, so forwarding it for imm forms is harmless.
  assign fwd_rs1 = wb_valid && (wb_rd != 5'd0) && (wb_rd == in_instr[19:15]);
  assign fwd_rs2 = wb_valid && (wb_rd != 5'd0) && (wb_rd == in_instr[24:20]);
  assign rs1_cap = fwd_rs1 ? wb_data : in_rs1_val;
  assign rs2_cap = fwd_rs2 ? wb_data : in_rs2_val;
`else
  assign rs1_cap = in_rs1_val;
  assign rs2_cap = in_rs2_val;
`endif

  shift_decode u_decode (
    .instr   (in_instr),
    .rs1_val (rs1_cap),
    .rs2_val (rs2_cap),
    .op      (dec_op)
  );

  logic      main_valid_q, main_valid_d;
  logic      skid_valid_q, skid_valid_d;
  logic      ready_q, ready_d;
  shift_op_t main_op_q, main_op_d;
  shift_op_t skid_op_q, skid_op_d;
  logic      accept;
  logic      drain;

  assign accept = in_valid && ready_q;
  assign drain  = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_op_d    = main_op_q;
    skid_valid_d = skid_valid_q;
    skid_op_d    = skid_op_q;
    ready_d      = ready_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      ready_d      = 1'b1;
    end else begin
      if (!main_valid_q || drain) begin
        // Skid entry is older than anything arriving now; it refills main first.
        if (skid_valid_q) begin
          main_valid_d = 1'b1;
          main_op_d    = skid_op_q;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_valid_d = 1'b1;
          main_op_d    = dec_op;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_op_d    = dec_op;
      end
      ready_d = !skid_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      main_op_q    <= '0;
      skid_op_q    <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
      main_op_q    <= main_op_d;
      skid_op_q    <= skid_op_d;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = main_valid_q;
  assign out_src     = main_op_q.src;
  assign out_num     = {{(XLEN-SHAMT_W){1'b0}}, main_op_q.num};
  assign out_dir     = main_op_q.dir;
  assign out_sign    = main_op_q.sign;
  assign out_rd      = main_op_q.rd;
  assign out_illegal = main_op_q.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage: directed scenarios then random traffic vs a queue model.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_dir, out_sign, out_illegal;
  logic [31:0] in_instr, in_rs1_val, in_rs2_val, out_src, out_num;
  logic [4:0]  out_rd;

  always #5 clk = ~clk;

  shift_issue_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs1_val  (in_rs1_val),
    .in_rs2_val  (in_rs2_val),
`ifdef SHIFT_ISSUE_FWD_EN
    .wb_valid    (1'b0),
    .wb_rd       (5'd0),
    .wb_data     (32'd0),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_src     (out_src),
    .out_num     (out_num),
    .out_dir     (out_dir),
    .out_sign    (out_sign),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  typedef struct {
    logic [31:0] src;
    logic [31:0] num;
    logic        dir;
    logic        sign;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t last_shown;
  exp_t zero_op;
  logic m_ready;
  logic last_acc;

  // Reference decode from the ISA mask/match table.
  function automatic exp_t ref_op(logic [31:0] ins, logic [31:0] rs1, logic [31:0] rs2);
    exp_t        e;
    logic [31:0] key;
    e.src  = rs1;
    e.rd   = ins[11:7];
    e.dir  = 1'b0;
    e.sign = 1'b0;
    e.num  = 32'd0;
    e.ill  = 1'b0;
    key    = ins & 32'hFE00_707F;
    case (key)
      32'h0000_1033: begin e.dir = 1'b1; e.num = rs2 % 32; end
      32'h0000_1013: begin e.dir = 1'b1; e.num = (ins >> 20) % 32; end
      32'h0000_5033: e.num = rs2 % 32;
      32'h0000_5013: e.num = (ins >> 20) % 32;
      32'h4000_5033: begin e.sign = 1'b1; e.num = rs2 % 32; end
      32'h4000_5013: begin e.sign = 1'b1; e.num = (ins >> 20) % 32; end
      default:       e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Check outputs mid-cycle, then advance one clock and update the model.
  task automatic step();
    exp_t h;
    exp_t cap;
    bit   acc, cons;
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    h = (q.size() > 0) ? q[0] : last_shown;
    chk("out_src", out_src, h.src);
    chk("out_num", out_num, h.num);
    chk("out_dir", {31'd0, out_dir}, {31'd0, h.dir});
    chk("out_sign", {31'd0, out_sign}, {31'd0, h.sign});
    chk("out_rd", {27'd0, out_rd}, {27'd0, h.rd});
    chk("out_illegal", {31'd0, out_illegal}, {31'd0, h.ill});
    if (q.size() > 0) last_shown = h;
    acc  = in_valid && m_ready && !flush && !rst;
    cons = (q.size() > 0) && out_ready && !flush && !rst;
    cap  = ref_op(in_instr, in_rs1_val, in_rs2_val);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_ready    = 1'b0;
      last_shown = zero_op;
    end else if (flush) begin
      q.delete();
      m_ready = 1'b1;
    end else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(cap);
      m_ready = (q.size() < 2);
    end
    last_acc = acc;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid   = 1'b1;
    in_instr   = ins;
    in_rs1_val = rs1;
    in_rs2_val = rs2;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0] opc, f7;
    logic [2:0] f3;
    int         r;
    r   = $urandom_range(0, 9);
    opc = (r < 5) ? 7'h13 : (r < 9) ? 7'h33 : 7'($urandom);
    r   = $urandom_range(0, 9);
    f3  = (r < 5) ? 3'b001 : (r < 9) ? 3'b101 : 3'($urandom);
    r   = $urandom_range(0, 9);
    f7  = (r < 5) ? 7'h00 : (r < 8) ? 7'h20 : (r < 9) ? 7'h01 : 7'($urandom);
    return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), opc};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_op    = '{src: 32'd0, num: 32'd0, dir: 1'b0, sign: 1'b0, rd: 5'd0, ill: 1'b0};
    last_shown = zero_op;
    m_ready    = 1'b0;
    last_acc   = 1'b0;
    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_instr   = 32'd0;
    in_rs1_val = 32'd0;
    in_rs2_val = 32'd0;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    step();

    // SLLI x5,x1,3 with rs1=1
    out_ready = 1'b1;
    present({7'h00, 5'd3, 5'd1, 3'b001, 5'd5, 7'h13}, 32'h1, 32'hDEAD_BEEF);
    step();
    in_valid = 1'b0;
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_num", out_num, 32'd3);
    chk("t1_dir", {31'd0, out_dir}, 32'd1);
    chk("t1_rd", {27'd0, out_rd}, 32'd5);
    step();

    // SRA with over-range rs2: amount masked to 4
    present({7'h20, 5'd2, 5'd1, 3'b101, 5'd7, 7'h33}, 32'h8000_0000, 32'hFFFF_FFE4);
    step();
    in_valid = 1'b0;
    chk("t2_num", out_num, 32'd4);
    chk("t2_sign", {31'd0, out_sign}, 32'd1);
    chk("t2_illegal", {31'd0, out_illegal}, 32'd0);
    step();

    // A,B,C back-to-back under a 3-cycle stall
    out_ready = 1'b0;
    present({7'h00, 5'd1, 5'd2, 3'b001, 5'd10, 7'h13}, 32'hA, 32'h0);
    step();
    present({7'h20, 5'd3, 5'd2, 3'b101, 5'd11, 7'h33}, 32'hB, 32'h7);
    step();
    present({7'h00, 5'd4, 5'd2, 3'b101, 5'd12, 7'h33}, 32'hC, 32'h9);
    step();
    chk("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 8 && !last_acc; k++) step();
    chk("t3_c_accepted", {31'd0, last_acc}, 32'd1);
    in_valid = 1'b0;
    repeat (4) step();

    // Fill both entries, then flush with an op on the input
    out_ready = 1'b0;
    present({7'h00, 5'd5, 5'd3, 3'b001, 5'd13, 7'h13}, 32'h11, 32'h0);
    step();
    present({7'h00, 5'd6, 5'd3, 3'b001, 5'd14, 7'h13}, 32'h22, 32'h0);
    step();
    present({7'h00, 5'd7, 5'd3, 3'b001, 5'd15, 7'h13}, 32'h33, 32'h0);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t4_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    step();

    // Illegal encodings: SLLI with instr[25]=1, then ADD
    out_ready = 1'b1;
    present({7'h01, 5'd3, 5'd1, 3'b001, 5'd4, 7'h13}, 32'h55, 32'h0);
    step();
    chk("t5_illegal", {31'd0, out_illegal}, 32'd1);
    present({7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}, 32'h66, 32'h3);
    step();
    in_valid = 1'b0;
    chk("t5_add_num", out_num, 32'd0);
    step();
    step();

    // Reset while stalled on a valid output
    out_ready = 1'b0;
    present({7'h20, 5'd9, 5'd1, 3'b101, 5'd9, 7'h13}, 32'hF0F0_0000, 32'h0);
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    step();

    // Random traffic with held payloads, stalls and occasional flush
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || last_acc || flush) begin
        present(gen_instr(), $urandom, $urandom);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      step();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
